// File: rtl/mips_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_mem_pkg
// Description : Shared definitions for the MIPS data-memory port. It holds the
//               access-size encodings, the controller state enum and a helper
//               that returns the byte count for an access size.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_mem_pkg;

  // Access-size encodings. 2'b11 is accepted as an alias of a word access.
  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Number of bytes touched by an access of the given size.
  function automatic logic [2:0] nbytes(input logic [1:0] size);
    case (size)
      SIZE_BYTE: nbytes = 3'd1;
      SIZE_HALF: nbytes = 3'd2;
      default:   nbytes = 3'd4;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/mips_dmem_lane.sv
`default_nettype none
// ============================================================================
// Module      : mips_dmem_lane
// Description : Combinational load formatter and alignment checker. It takes
//               the four bytes starting at the access address (byte 0 in the
//               low lane), keeps 1/2/4 of them and sign- or zero-extends to 32
//               bits. It also flags misaligned half/word accesses.
// Ports       : size       - access size (byte/half/word)
//               sign_ext   - 1 = sign-extend loads, 0 = zero-extend
//               addr_lo    - low two bits of the byte address
//               raw_bytes  - bytes at addr+0..addr+3, little-endian packed
//               load_data  - formatted load result
//               misaligned - half with addr[0]=1 or word with addr[1:0]!=0
// Revision    : 1.0 - initial release
// ============================================================================
module mips_dmem_lane
  import mips_mem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] raw_bytes,
  output logic [31:0] load_data,
  output logic        misaligned
);

  always_comb begin
    load_data  = raw_bytes;
    misaligned = 1'b0;
    case (size)
      SIZE_BYTE: begin
        load_data = {{24{sign_ext & raw_bytes[7]}}, raw_bytes[7:0]};
      end
      SIZE_HALF: begin
        load_data  = {{16{sign_ext & raw_bytes[15]}}, raw_bytes[15:0]};
        misaligned = addr_lo[0];
      end
      default: begin
        load_data  = raw_bytes;
        misaligned = (addr_lo != 2'b00);
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mips_dmem_port.sv
`default_nettype none
// ============================================================================
// Module      : mips_dmem_port
// Description : Single-clock byte-addressable data memory with a valid/ready
//               request interface, configurable wait states, little-endian
//               byte/half/word access, sign/zero extension and an error flag
//               for misaligned or out-of-range accesses.
// Ports       : clk, reset          - clock, async active-high reset
//               req_valid/req_ready - request handshake (ready only in IDLE)
//               req_write           - 1 = store, 0 = load
//               req_size            - 00 byte, 01 half, 1x word
//               req_signed          - load extension select
//               req_addr, req_wdata - byte address and store data
//               resp_valid          - one-cycle response pulse
//               resp_rdata          - load result (0 on store or error)
//               resp_error          - misaligned / out-of-range flag
// Revision    : 1.0 - initial release
// ============================================================================
module mips_dmem_port
  import mips_mem_pkg::*;
#(
  parameter int ADDR_WIDTH  = 17,
  parameter int DEPTH_BYTES = 512,
  parameter int WAIT_STATES = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [1:0]            req_size,
  input  logic                  req_signed,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  output logic [31:0]           resp_rdata,
  output logic                  resp_error
);

  localparam int                IDX_W     = (DEPTH_BYTES > 1) ? $clog2(DEPTH_BYTES) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_EXT = (ADDR_WIDTH+1)'(DEPTH_BYTES);
  localparam logic [3:0]        WAIT_LOAD = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  state_t     state, state_nxt;
  logic [3:0] cnt, cnt_nxt;

  // Latched request fields, held for the whole transaction.
  logic                  lat_write;
  logic [1:0]            lat_size;
  logic                  lat_signed;
  logic [ADDR_WIDTH-1:0] lat_addr;
  logic [31:0]           lat_wdata;

  logic [7:0] mem [DEPTH_BYTES];

  // With zero wait states the access happens on the accept edge itself, so
  // the live request is used while in IDLE and the latched copy afterwards.
  logic                  acc_write;
  logic [1:0]            acc_size;
  logic                  acc_signed;
  logic [ADDR_WIDTH-1:0] acc_addr;
  logic [31:0]           acc_wdata;

  logic                  accept;
  logic                  commit;
  logic                  misaligned;
  logic                  out_of_range;
  logic                  acc_error;
  logic [2:0]            acc_nbytes;
  logic [ADDR_WIDTH:0]   byte_addr [4];
  logic [31:0]           raw_bytes;
  logic [31:0]           load_data;

  assign req_ready  = (state == ST_IDLE);
  assign resp_valid = (state == ST_RESP);
  assign accept     = req_valid & req_ready;

  assign acc_write  = (state == ST_IDLE) ? req_write  : lat_write;
  assign acc_size   = (state == ST_IDLE) ? req_size   : lat_size;
  assign acc_signed = (state == ST_IDLE) ? req_signed : lat_signed;
  assign acc_addr   = (state == ST_IDLE) ? req_addr   : lat_addr;
  assign acc_wdata  = (state == ST_IDLE) ? req_wdata  : lat_wdata;

  // The access is performed on the edge that enters RESP; reset suppresses it
  // so an aborted store never reaches the array.
  assign commit = (state_nxt == ST_RESP) && (state != ST_RESP) && !reset;

  assign acc_nbytes   = nbytes(acc_size);
  assign out_of_range = ({1'b0, acc_addr} + (ADDR_WIDTH+1)'(acc_nbytes)) > DEPTH_EXT;
  assign acc_error    = misaligned | out_of_range;

  // Gather the four bytes starting at the access address; bytes past the end
  // of storage read as zero and are never written.
  for (genvar i = 0; i < 4; i++) begin : g_rd_lane
    assign byte_addr[i] = {1'b0, acc_addr} + (ADDR_WIDTH+1)'(i);
    assign raw_bytes[8*i +: 8] = (byte_addr[i] < DEPTH_EXT) ?
                                 mem[byte_addr[i][IDX_W-1:0]] : 8'h00;
  end

  mips_dmem_lane u_lane (
    .size       (acc_size),
    .sign_ext   (acc_signed),
    .addr_lo    (acc_addr[1:0]),
    .raw_bytes  (raw_bytes),
    .load_data  (load_data),
    .misaligned (misaligned)
  );

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      ST_IDLE: begin
        if (req_valid) begin
          if (WAIT_STATES == 0) begin
            state_nxt = ST_RESP;
          end else begin
            state_nxt = ST_WAIT;
            cnt_nxt   = WAIT_LOAD;
          end
        end
      end
      ST_WAIT: begin
        if (cnt == 4'd0) state_nxt = ST_RESP;
        else             cnt_nxt   = cnt - 4'd1;
      end
      ST_RESP: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      cnt        <= 4'd0;
      resp_rdata <= 32'd0;
      resp_error <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (commit) begin
        resp_rdata <= (acc_write || acc_error) ? 32'd0 : load_data;
        resp_error <= acc_error;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      lat_write  <= req_write;
      lat_size   <= req_size;
      lat_signed <= req_signed;
      lat_addr   <= req_addr;
      lat_wdata  <= req_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (commit && acc_write && !acc_error) begin
      for (int i = 0; i < 4; i++) begin
        if (3'(i) < acc_nbytes) mem[byte_addr[i][IDX_W-1:0]] <= acc_wdata[8*i +: 8];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mips_dmem_port.sv
`default_nettype none
// ============================================================================
// Module      : tb_mips_dmem_port
// Description : Directed bench for mips_dmem_port. Three instances share the
//               request fields: index 0 has 1 wait state, index 1 has 3 and
//               index 2 has 0; each has its own req_valid.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mips_dmem_port;
  import mips_mem_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [16:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  valid;
  logic [2:0]  ready;
  logic [2:0]  rvalid;
  logic [2:0]  rerr;
  logic [31:0] rdata [3];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mips_dmem_port #(.ADDR_WIDTH(17), .DEPTH_BYTES(512), .WAIT_STATES(1)) u_dut_ws1 (
    .clk(clk), .reset(reset), .req_valid(valid[0]), .req_ready(ready[0]),
    .req_write(req_write), .req_size(req_size), .req_signed(req_signed),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(rvalid[0]),
    .resp_rdata(rdata[0]), .resp_error(rerr[0])
  );

  mips_dmem_port #(.ADDR_WIDTH(17), .DEPTH_BYTES(512), .WAIT_STATES(3)) u_dut_ws3 (
    .clk(clk), .reset(reset), .req_valid(valid[1]), .req_ready(ready[1]),
    .req_write(req_write), .req_size(req_size), .req_signed(req_signed),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(rvalid[1]),
    .resp_rdata(rdata[1]), .resp_error(rerr[1])
  );

  mips_dmem_port #(.ADDR_WIDTH(17), .DEPTH_BYTES(512), .WAIT_STATES(0)) u_dut_ws0 (
    .clk(clk), .reset(reset), .req_valid(valid[2]), .req_ready(ready[2]),
    .req_write(req_write), .req_size(req_size), .req_signed(req_signed),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(rvalid[2]),
    .resp_rdata(rdata[2]), .resp_error(rerr[2])
  );

  task automatic check(input string tag, input string what,
                       input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s.%s observed=0x%08h expected=0x%08h", tag, what, obs, exp);
    end
  endtask

  task automatic set_req(input logic w, input logic [1:0] sz, input logic sg,
                         input logic [16:0] a, input logic [31:0] wd);
    req_write  = w;
    req_size   = sz;
    req_signed = sg;
    req_addr   = a;
    req_wdata  = wd;
  endtask

  // One complete transaction on instance d, checking latency, payload and the
  // single-cycle width of the response pulse.
  task automatic xact(input int d, input string tag, input logic w,
                      input logic [1:0] sz, input logic sg, input logic [16:0] a,
                      input logic [31:0] wd, input int ws,
                      input logic [31:0] exp_rd, input logic exp_er);
    int lat;
    bit got;
    @(negedge clk);
    check(tag, "ready_before", 32'(ready[d]), 32'd1);
    set_req(w, sz, sg, a, wd);
    valid[d] = 1'b1;
    @(posedge clk);
    #1 valid[d] = 1'b0;
    lat = 0;
    got = 1'b0;
    while (!got && lat < 20) begin
      @(negedge clk);
      lat++;
      if (rvalid[d]) got = 1'b1;
    end
    check(tag, "latency", 32'(lat), 32'(ws + 1));
    check(tag, "rdata", rdata[d], exp_rd);
    check(tag, "error", 32'(rerr[d]), 32'(exp_er));
    @(negedge clk);
    check(tag, "pulse_end", 32'(rvalid[d]), 32'd0);
  endtask

  // Back-to-back vectors for the zero-wait-state instance.
  logic        b_w  [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
  logic [1:0]  b_sz [4] = '{SIZE_WORD, SIZE_WORD, SIZE_BYTE, SIZE_HALF};
  logic        b_sg [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
  logic [16:0] b_a  [4] = '{17'h8, 17'h8, 17'hB, 17'h9};
  logic [31:0] b_wd [4] = '{32'hA1B2C3D4, 32'h0, 32'h0, 32'h0};
  logic [31:0] b_rd [4] = '{32'h0, 32'hA1B2C3D4, 32'hFFFFFFA1, 32'h0};
  logic        b_er [4] = '{1'b0, 1'b0, 1'b0, 1'b1};

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    reset = 1'b1;
    valid = 3'b000;
    set_req(1'b0, SIZE_WORD, 1'b0, 17'h0, 32'h0);
    repeat (2) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      check("reset", "ready", 32'(ready[d]), 32'd1);
      check("reset", "resp_valid", 32'(rvalid[d]), 32'd0);
      check("reset", "rdata", rdata[d], 32'd0);
      check("reset", "error", 32'(rerr[d]), 32'd0);
    end
    reset = 1'b0;

    // One wait state: basic word/byte/half traffic and error cases.
    xact(0, "st_w10",  1, SIZE_WORD, 0, 17'h10,  32'hDEADBEEF, 1, 32'h0,        0);
    xact(0, "ld_w10",  0, SIZE_WORD, 0, 17'h10,  32'h0,        1, 32'hDEADBEEF, 0);
    xact(0, "st_b21",  1, SIZE_BYTE, 0, 17'h21,  32'h00000080, 1, 32'h0,        0);
    xact(0, "ld_b21s", 0, SIZE_BYTE, 1, 17'h21,  32'h0,        1, 32'hFFFFFF80, 0);
    xact(0, "ld_b21u", 0, SIZE_BYTE, 0, 17'h21,  32'h0,        1, 32'h00000080, 0);
    xact(0, "st_h30",  1, SIZE_HALF, 0, 17'h30,  32'h00008001, 1, 32'h0,        0);
    xact(0, "ld_h30s", 0, SIZE_HALF, 1, 17'h30,  32'h0,        1, 32'hFFFF8001, 0);
    xact(0, "ld_h30u", 0, SIZE_HALF, 0, 17'h30,  32'h0,        1, 32'h00008001, 0);
    xact(0, "ld_b31u", 0, SIZE_BYTE, 0, 17'h31,  32'h0,        1, 32'h00000080, 0);
    xact(0, "ld_w13",  0, SIZE_WORD, 0, 17'h13,  32'h0,        1, 32'h0,        1);
    xact(0, "st_w14",  1, SIZE_WORD, 0, 17'h14,  32'hCAFEF00D, 1, 32'h0,        0);
    xact(0, "ld_w14",  0, SIZE_WORD, 0, 17'h14,  32'h0,        1, 32'hCAFEF00D, 0);
    xact(0, "st_h1fe", 1, SIZE_HALF, 0, 17'h1FE, 32'h0000A55A, 1, 32'h0,        0);
    xact(0, "st_w1fe", 1, SIZE_WORD, 0, 17'h1FE, 32'h11223344, 1, 32'h0,        1);
    xact(0, "ld_h1fe", 0, SIZE_HALF, 0, 17'h1FE, 32'h0,        1, 32'h0000A55A, 0);
    xact(0, "ld_w200", 0, SIZE_WORD, 0, 17'h200, 32'h0,        1, 32'h0,        1);
    xact(0, "st_b200", 1, SIZE_BYTE, 0, 17'h200, 32'h000000EE, 1, 32'h0,        1);
    xact(0, "ld_b1ff", 0, SIZE_BYTE, 1, 17'h1FF, 32'h0,        1, 32'hFFFFFFA5, 0);

    // Three wait states: reset while WAIT aborts a pending store.
    xact(1, "pre_w40", 1, SIZE_WORD, 0, 17'h40, 32'h0BADF00D, 3, 32'h0, 0);
    @(negedge clk);
    set_req(1'b1, SIZE_WORD, 1'b0, 17'h40, 32'h12345678);
    valid[1] = 1'b1;
    @(posedge clk);
    #1 valid[1] = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check("abort", "ready_in_reset", 32'(ready[1]), 32'd1);
    check("abort", "resp_valid_in_reset", 32'(rvalid[1]), 32'd0);
    reset = 1'b0;
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (rvalid[1]) seen = 1'b1;
    end
    check("abort", "no_response", 32'(seen), 32'd0);
    check("abort", "ready_after", 32'(ready[1]), 32'd1);
    xact(1, "ld_w40", 0, SIZE_WORD, 0, 17'h40, 32'h0, 3, 32'h0BADF00D, 0);

    // Zero wait states: req_valid held high across four requests.
    @(negedge clk);
    set_req(b_w[0], b_sz[0], b_sg[0], b_a[0], b_wd[0]);
    valid[2] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("b2b%0d", k), "ready_idle", 32'(ready[2]), 32'd1);
      check($sformatf("b2b%0d", k), "valid_idle", 32'(rvalid[2]), 32'd0);
      @(posedge clk);
      @(negedge clk);
      check($sformatf("b2b%0d", k), "resp_valid", 32'(rvalid[2]), 32'd1);
      check($sformatf("b2b%0d", k), "ready_resp", 32'(ready[2]), 32'd0);
      check($sformatf("b2b%0d", k), "rdata", rdata[2], b_rd[k]);
      check($sformatf("b2b%0d", k), "error", 32'(rerr[2]), 32'(b_er[k]));
      if (k < 3) set_req(b_w[k+1], b_sz[k+1], b_sg[k+1], b_a[k+1], b_wd[k+1]);
      @(negedge clk);
    end
    valid[2] = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mips_dmem_port.md
# mips_dmem_port

Parametrised, single-clock, byte-addressable data memory for the MIPS datapath, replacing the fixed 501-byte, dual-edge data memory. It accepts one load/store request at a time over a valid/ready handshake and returns a one-cycle response after a configurable number of wait states. It adds sign/zero extension, misalignment and range checking, and an error flag. It sits between the MEM stage and the backing byte array and owns that array.

## Interface
- ADDR_WIDTH, 17, byte-address width.
- DEPTH_BYTES, 512, storage size in bytes; must be a multiple of 4 and at most 2**ADDR_WIDTH.
- WAIT_STATES, 1, extra cycles between accept and response; range 0..15.
- clk  in  1  clock; all state changes on posedge only.
- reset  in  1  asynchronous, active-high; clears control state only.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request; high only in IDLE.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 word (alias).
- req_signed  in  1  loads only: 1 = sign-extend, 0 = zero-extend.
- req_addr  in  ADDR_WIDTH  byte address.
- req_wdata  in  32  store data; low bytes used for byte/half.
- resp_valid  out  1  one-cycle response pulse; no backpressure.
- resp_rdata  out  32  load result; 0 for stores and errors.
- resp_error  out  1  qualified by resp_valid; misaligned or out-of-range access.

## Operation
- States: IDLE, WAIT, RESP.
  - IDLE: req_ready=1. On req_valid, latch all request fields. Go to WAIT if WAIT_STATES>0, else RESP.
  - WAIT: count down WAIT_STATES cycles, then go to RESP.
  - RESP: resp_valid=1 for exactly one cycle, then go to IDLE.
- Memory access happens on the clock edge that enters RESP.
  - Store: writes 1/2/4 bytes, little-endian (byte at addr = wdata[7:0]).
  - Load: assembles bytes little-endian, then extends per req_signed.
- Error checks, evaluated on the latched request:
  - Misaligned: half with addr[0]=1, or word with addr[1:0]!=0.
  - Out of range: addr + nbytes > DEPTH_BYTES.
  - On error: no bytes written, resp_rdata=0, resp_error=1.
- Storage contents are not reset and are undefined until written.
- Reset during WAIT: abort to IDLE; the pending store is not committed and no response is issued.
- Inputs are ignored outside IDLE; latched fields are stable for the whole transaction.

## Timing
- Reset values: req_ready=1, resp_valid=0, resp_rdata=0, resp_error=0, state=IDLE, counter=0.
- Request accepted at edge T (req_valid & req_ready). resp_valid is high in cycle T+1+WAIT_STATES.
- Throughput: one request per WAIT_STATES+2 cycles. req_ready returns high the cycle after RESP.
- resp_rdata and resp_error are registered and hold their value until the next RESP. Consumers qualify them with resp_valid only.
- Read-after-write to the same address returns the new data: the store commits before RESP ends.

## Structure
- Shared package mips_mem_pkg holds:
  - size encodings SIZE_BYTE/SIZE_HALF/SIZE_WORD;
  - the state enum;
  - function nbytes(size).
- One combinational sub-module, mips_dmem_lane, handles load byte assembly, sign/zero extension and the alignment check. The FSM, counter and storage stay in the top module.

## Test plan
- WAIT_STATES=1. Store word 0xDEADBEEF at 0x10, then load word 0x10 -> resp_valid 2 cycles after each accept, rdata=0xDEADBEEF, error=0.
- Store byte 0x80 at 0x21, then load byte 0x21:
  - signed -> 0xFFFFFF80;
  - unsigned -> 0x00000080.
- Store half 0x8001 at 0x30, then load half 0x30:
  - signed -> 0xFFFF8001;
  - unsigned -> 0x00008001;
  - byte 0x31 -> 0x00000080 unsigned.
- Load word at 0x13 -> error=1, rdata=0. Store word at 0x14 with DEPTH_BYTES=512 then at 0x1FE -> first ok, second error=1 and bytes 0x1FE/0x1FF unchanged.
- WAIT_STATES=3. Assert reset one cycle after accepting a store of 0x12345678 to 0x40 -> no resp_valid, req_ready=1 after reset, later load 0x40 != 0x12345678.
- WAIT_STATES=0, req_valid held high with 4 back-to-back requests -> accepts every 2 cycles, resp_valid pulses at T+1, req_ready low in each RESP cycle.
